// File: rtl/jk_seq_driver.sv
// Drives a JK flip-flop's j/k so its q follows a pattern MSB-first, then checks q per bit.
// Optional build macro JK_TOGGLE_EN selects toggle excitation (from q_fb) instead of set/reset.
module jk_seq_driver #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             mismatch,
    output logic             done,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_dec;
    logic               j_q, j_d, k_q, k_d;
    logic               mm_q, mm_d, done_q, done_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [1:0]         jk_first, jk_next;

    assign idx_dec = idx_q - 1'b1;

    // jk_first excites the MSB at accept; jk_next the following bit when leaving CHECK.
`ifdef JK_TOGGLE_EN
    assign jk_first = {2{pattern[WIDTH-1] ^ q_fb}};
    assign jk_next  = {2{pat_q[idx_dec] ^ q_fb}};
`else
    assign jk_first = {pattern[WIDTH-1], ~pattern[WIDTH-1]};
    assign jk_next  = {pat_q[idx_dec], ~pat_q[idx_dec]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            mm_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            k_q     <= k_d;
            mm_q    <= mm_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        j_d     = j_q;
        k_d     = k_q;
        mm_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    pat_d      = pattern;
                    idx_d      = IDX_W'(WIDTH - 1);
                    err_d      = '0;
                    {j_d, k_d} = jk_first;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb != pat_q[idx_q]) begin
                    mm_d = 1'b1;
                    if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                end
                if (idx_q == '0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d      = idx_dec;
                    {j_d, k_d} = jk_next;
                    state_d    = DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == DRIVE) || (state_q == CHECK);
    assign j           = j_q;
    assign k           = k_q;
    // Pulses are masked while reset is high so they can never coincide with it.
    assign mismatch    = mm_q & ~reset;
    assign done        = done_q & ~reset;
    assign err_count   = err_q;

endmodule
